// File: rtl/modulo_divider_param.sv
// Sequential radix-2 restoring divide/modulo unit, one quotient bit per cycle.
// Signed operands are handled as magnitudes with a final sign fix-up step.
module modulo_divider_param #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] Zahl1_i,
  input  logic [WIDTH-1:0] Zahl2_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic [WIDTH-1:0] ergebnis_o
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic             accept;
  logic             b_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] div_q;
  logic             mode_q;
  logic             neg_quot_q;
  logic             neg_rem_q;

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Start is honoured whenever the unit is not busy, including the DONE cycle.
  assign accept = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign b_zero = (Zahl2_i == '0);

  always_comb begin
    a_neg = signed_i & Zahl1_i[WIDTH-1];
    b_neg = signed_i & Zahl2_i[WIDTH-1];
    a_mag = a_neg ? (~Zahl1_i + 1'b1) : Zahl1_i;
    b_mag = b_neg ? (~Zahl2_i + 1'b1) : Zahl2_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = b_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
      end
      DONE: begin
        if (accept) begin
          state_d = b_zero ? DONE : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy_o  = (state_q == CALC) || (state_q == FIX);
    valid_o = (state_q == DONE);
  end

  // Shift in one extra top bit so the trial-subtract borrow lands in trial[WIDTH+1].
  always_comb begin
    rem_sh   = {rem_q, dvd_q[WIDTH-1]};
    trial    = rem_sh - {2'b00, div_q};
    trial_ok = ~trial[WIDTH+1];
    q_fix    = neg_quot_q ? (~dvd_q + 1'b1) : dvd_q;
    r_fix    = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      div_q       <= '0;
      mode_q      <= 1'b0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_o  <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      ergebnis_o  <= '0;
    end else if (accept) begin
      mode_q     <= mode_i;
      neg_quot_q <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      rem_q      <= '0;
      dvd_q      <= a_mag;
      div_q      <= b_mag;
      cnt_q      <= CNT_W'(WIDTH - 1);
      div_zero_o <= b_zero;
      // Divide by zero goes straight to DONE, so its results are committed here.
      if (b_zero) begin
        quotient_o  <= '1;
        remainder_o <= Zahl1_i;
        ergebnis_o  <= mode_i ? '1 : Zahl1_i;
      end
    end else if (state_q == CALC) begin
      rem_q <= trial_ok ? trial[WIDTH:0] : rem_sh[WIDTH:0];
      dvd_q <= {dvd_q[WIDTH-2:0], trial_ok};
      cnt_q <= cnt_q - 1'b1;
    end else if (state_q == FIX) begin
      quotient_o  <= q_fix;
      remainder_o <= r_fix;
      ergebnis_o  <= mode_q ? q_fix : r_fix;
    end
  end

endmodule

// File: tb/tb_modulo_divider_param.sv
// Scoreboard bench for modulo_divider_param (WIDTH=16): expected results are
// queued at start and compared when valid_o appears.
module tb_modulo_divider_param;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic         mode_i;
  logic         signed_i;
  logic [W-1:0] Zahl1_i;
  logic [W-1:0] Zahl2_i;
  logic         busy_o;
  logic         valid_o;
  logic         div_zero_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic [W-1:0] ergebnis_o;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [W-1:0] e;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  modulo_divider_param #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .signed_i   (signed_i),
    .Zahl1_i    (Zahl1_i),
    .Zahl2_i    (Zahl2_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .div_zero_o (div_zero_o),
    .quotient_o (quotient_o),
    .remainder_o(remainder_o),
    .ergebnis_o (ergebnis_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic s, logic m);
    exp_t x;
    logic signed [W-1:0] sa, sbv;
    sa  = a;
    sbv = b;
    if (b == '0) begin
      x.q   = '1;
      x.r   = a;
      x.dz  = 1'b1;
      x.lat = 1;
    end else begin
      x.dz  = 1'b0;
      x.lat = W + 2;
      if (s && a == 16'h8000 && b == 16'hFFFF) begin
        x.q = 16'h8000;
        x.r = '0;
      end else if (s) begin
        x.q = sa / sbv;
        x.r = sa % sbv;
      end else begin
        x.q = a / b;
        x.r = a % b;
      end
    end
    x.e = m ? x.q : x.r;
    return x;
  endfunction

  // Pushes the expectation, holds start over one edge, then scrambles the inputs.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic m);
    Zahl1_i  = a;
    Zahl2_i  = b;
    signed_i = s;
    mode_i   = m;
    start_i  = 1'b1;
    sb.push_back(model(a, b, s, m));
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    Zahl1_i  = W'($urandom);
    Zahl2_i  = W'($urandom);
    signed_i = 1'($urandom);
    mode_i   = 1'($urandom);
  endtask

  task automatic wait_valid(input int l0, output int lat);
    lat = l0;
    while (valid_o !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    mode_i   = 1'b0;
    signed_i = 1'b0;
    Zahl1_i  = '0;
    Zahl2_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (busy_o !== 1'b0) begin nmis++; $display("FAIL reset_busy got %b want 0", busy_o); end
    nvec++; if (valid_o !== 1'b0) begin nmis++; $display("FAIL reset_valid got %b want 0", valid_o); end
    nvec++; if (div_zero_o !== 1'b0) begin nmis++; $display("FAIL reset_dz got %b want 0", div_zero_o); end
    nvec++; if (quotient_o !== '0) begin nmis++; $display("FAIL reset_quot got %h want 0", quotient_o); end
    nvec++; if (remainder_o !== '0) begin nmis++; $display("FAIL reset_rem got %h want 0", remainder_o); end
    nvec++; if (ergebnis_o !== '0) begin nmis++; $display("FAIL reset_erg got %h want 0", ergebnis_o); end
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned;
    exp_t e;
    int   lat;
    start_op(16'd100, 16'd7, 1'b0, 1'b0);
    nvec++; if (busy_o !== 1'b1) begin nmis++; $display("FAIL t1_busy got %b want 1", busy_o); end
    wait_valid(1, lat);
    e = sb.pop_front();
    nvec++; if (lat != e.lat) begin nmis++; $display("FAIL t1_latency got %0d want %0d", lat, e.lat); end
    nvec++; if (ergebnis_o !== 16'd2) begin nmis++; $display("FAIL t1_erg got %0d want 2", ergebnis_o); end
    nvec++; if (quotient_o !== 16'd14) begin nmis++; $display("FAIL t1_quot got %0d want 14", quotient_o); end
    nvec++; if (div_zero_o !== 1'b0) begin nmis++; $display("FAIL t1_dz got %b want 0", div_zero_o); end
    nvec++; if (ergebnis_o !== e.e) begin nmis++; $display("FAIL t1_erg_model got %h want %h", ergebnis_o, e.e); end
    @(posedge clk);
    #1;
    nvec++; if (valid_o !== 1'b0) begin nmis++; $display("FAIL t1_valid_pulse got %b want 0", valid_o); end
  endtask

  task automatic test_signed;
    exp_t e;
    int   lat;
    start_op(16'hFFF9, 16'd2, 1'b1, 1'b1);
    wait_valid(1, lat);
    e = sb.pop_front();
    nvec++; if (lat != e.lat) begin nmis++; $display("FAIL t2_latency got %0d want %0d", lat, e.lat); end
    nvec++; if (quotient_o !== 16'hFFFD) begin nmis++; $display("FAIL t2_quot got %h want fffd", quotient_o); end
    nvec++; if (remainder_o !== 16'hFFFF) begin nmis++; $display("FAIL t2_rem got %h want ffff", remainder_o); end
    nvec++; if (ergebnis_o !== e.e) begin nmis++; $display("FAIL t2_erg got %h want %h", ergebnis_o, e.e); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_div_zero;
    exp_t e;
    int   lat;
    start_op(16'd1234, 16'd0, 1'b0, 1'b0);
    wait_valid(1, lat);
    e = sb.pop_front();
    nvec++; if (lat != 1) begin nmis++; $display("FAIL t3_latency got %0d want 1", lat); end
    nvec++; if (div_zero_o !== 1'b1) begin nmis++; $display("FAIL t3_dz got %b want 1", div_zero_o); end
    nvec++; if (quotient_o !== 16'hFFFF) begin nmis++; $display("FAIL t3_quot got %h want ffff", quotient_o); end
    nvec++; if (remainder_o !== 16'd1234) begin nmis++; $display("FAIL t3_rem got %0d want 1234", remainder_o); end
    nvec++; if (ergebnis_o !== e.e) begin nmis++; $display("FAIL t3_erg got %h want %h", ergebnis_o, e.e); end
    start_op(16'd9, 16'd3, 1'b0, 1'b1);
    nvec++; if (div_zero_o !== 1'b0) begin nmis++; $display("FAIL t3_dz_clear got %b want 0", div_zero_o); end
    wait_valid(1, lat);
    e = sb.pop_front();
    nvec++; if (lat != e.lat) begin nmis++; $display("FAIL t3b_latency got %0d want %0d", lat, e.lat); end
    nvec++; if (quotient_o !== 16'd3) begin nmis++; $display("FAIL t3b_quot got %0d want 3", quotient_o); end
    nvec++; if (div_zero_o !== 1'b0) begin nmis++; $display("FAIL t3b_dz got %b want 0", div_zero_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow;
    exp_t e;
    int   lat;
    start_op(16'h8000, 16'hFFFF, 1'b1, 1'b1);
    wait_valid(1, lat);
    e = sb.pop_front();
    nvec++; if (quotient_o !== 16'h8000) begin nmis++; $display("FAIL t4_quot got %h want 8000", quotient_o); end
    nvec++; if (remainder_o !== 16'h0000) begin nmis++; $display("FAIL t4_rem got %h want 0000", remainder_o); end
    nvec++; if (ergebnis_o !== e.e) begin nmis++; $display("FAIL t4_erg got %h want %h", ergebnis_o, e.e); end
    start_op(16'hFFFF, 16'd1, 1'b0, 1'b0);
    wait_valid(1, lat);
    e = sb.pop_front();
    nvec++; if (quotient_o !== 16'hFFFF) begin nmis++; $display("FAIL t4b_quot got %h want ffff", quotient_o); end
    nvec++; if (remainder_o !== 16'h0000) begin nmis++; $display("FAIL t4b_rem got %h want 0000", remainder_o); end
    nvec++; if (ergebnis_o !== e.e) begin nmis++; $display("FAIL t4b_erg got %h want %h", ergebnis_o, e.e); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   lat;
    start_op(16'd1000, 16'd33, 1'b0, 1'b1);
    lat = 1;
    repeat (4) begin
      @(posedge clk);
      #1;
      lat++;
    end
    // Cycle T+5: a start while busy must be dropped, not queued.
    Zahl1_i = 16'd5;
    Zahl2_i = 16'd1;
    mode_i  = 1'b0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start_i = 1'b0;
    wait_valid(lat, lat);
    e = sb.pop_front();
    nvec++; if (lat != e.lat) begin nmis++; $display("FAIL t5_latency got %0d want %0d", lat, e.lat); end
    nvec++; if (quotient_o !== e.q) begin nmis++; $display("FAIL t5_quot got %0d want %0d", quotient_o, e.q); end
    nvec++; if (ergebnis_o !== e.e) begin nmis++; $display("FAIL t5_erg got %0d want %0d", ergebnis_o, e.e); end
    start_op(16'hFF00, 16'd10, 1'b1, 1'b0);
    nvec++; if (busy_o !== 1'b1) begin nmis++; $display("FAIL t5b_busy got %b want 1", busy_o); end
    wait_valid(1, lat);
    e = sb.pop_front();
    nvec++; if (lat != W + 2) begin nmis++; $display("FAIL t5b_latency got %0d want %0d", lat, W + 2); end
    nvec++; if (remainder_o !== e.r) begin nmis++; $display("FAIL t5b_rem got %h want %h", remainder_o, e.r); end
    nvec++; if (quotient_o !== e.q) begin nmis++; $display("FAIL t5b_quot got %h want %h", quotient_o, e.q); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort;
    exp_t e;
    int   seen;
    start_op(16'd500, 16'd3, 1'b0, 1'b1);
    e = sb.pop_front();
    repeat (7) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    nvec++; if (busy_o !== 1'b0) begin nmis++; $display("FAIL t6_busy got %b want 0", busy_o); end
    nvec++; if (valid_o !== 1'b0) begin nmis++; $display("FAIL t6_valid got %b want 0", valid_o); end
    nvec++; if (quotient_o !== '0) begin nmis++; $display("FAIL t6_quot got %h want 0", quotient_o); end
    nvec++; if (remainder_o !== '0) begin nmis++; $display("FAIL t6_rem got %h want 0", remainder_o); end
    nvec++; if (ergebnis_o !== '0) begin nmis++; $display("FAIL t6_erg got %h want 0", ergebnis_o); end
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (valid_o === 1'b1) seen++;
    end
    nvec++; if (seen != 0) begin nmis++; $display("FAIL t6_no_valid got %0d pulses want 0", seen); end
  endtask

  task automatic test_random;
    exp_t         e;
    int           lat;
    logic [W-1:0] a, b;
    logic         s, m;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom);
      m = 1'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      if (i % 13 == 5) begin
        a = 16'h8000;
        b = 16'hFFFF;
        s = 1'b1;
      end
      if (i % 3 == 0) b = b & 16'h00FF;
      start_op(a, b, s, m);
      wait_valid(1, lat);
      e = sb.pop_front();
      nvec++; if (lat != e.lat) begin nmis++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, e.lat); end
      nvec++; if (quotient_o !== e.q) begin nmis++; $display("FAIL rnd%0d_quot a=%h b=%h s=%b got %h want %h", i, a, b, s, quotient_o, e.q); end
      nvec++; if (remainder_o !== e.r) begin nmis++; $display("FAIL rnd%0d_rem a=%h b=%h s=%b got %h want %h", i, a, b, s, remainder_o, e.r); end
      nvec++; if (ergebnis_o !== e.e) begin nmis++; $display("FAIL rnd%0d_erg got %h want %h", i, ergebnis_o, e.e); end
      nvec++; if (div_zero_o !== e.dz) begin nmis++; $display("FAIL rnd%0d_dz got %b want %b", i, div_zero_o, e.dz); end
      if ((i % 4) == 3) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_overflow;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
